// File: rtl/ram_bus_arbiter.sv
// Shared RAM bus arbiter between the CPU port and the video scan port.
// Drives the active-low 74244 buffer enables and RAM strobes, captures read
// data for whichever requester owns the bus, and inserts one TURN cycle with
// every enable released between owners so buffer outputs never contend.
module ram_bus_arbiter #(
  parameter int ACC_CYC = 2,  // CPU access strobe length in clocks, 1..4
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cpu_req,
  input  logic          cpu_rnw,
  output logic [DW-1:0] cpu_din,
  output logic          cpu_ack,
  output logic          cpu_waitn,
  input  logic          vid_req,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  output logic          vid_ovr,
  input  logic [DW-1:0] ram_dq_in,
  output logic          cpu_a_gn,
  output logic          cpu_d_gn,
  output logic          vid_a_gn,
  output logic          ram_oen,
  output logic          ram_wen
);

  typedef enum logic [2:0] {
    IDLE,
    VID_ADDR,
    VID_DATA,
    CPU_ADDR,
    CPU_ACC,
    TURN
  } state_t;

  // The CPU_ACC down-counter starts here and leaves the state when it hits 0.
  localparam logic [1:0] ACC_LOAD = 2'(ACC_CYC - 1);

  state_t     state, state_nxt;
  logic [1:0] acc_cnt;
  logic       vid_pend;
  logic       cpu_rd;        // direction of the CPU access in progress
  logic       last_cpu;      // the access that led into TURN was a CPU access
  logic       free;          // bus may be granted this cycle
  logic       go_vid;
  logic       go_cpu;
  logic       rd_nxt;

  // The CPU holds its request until it sees the ack.
  assign cpu_waitn = ~(cpu_req & ~cpu_ack);

  // Grant decision and next-state selection; video always wins.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    state_nxt = state;
    free      = (state == IDLE) || (state == TURN);
    go_vid    = free && (vid_req || vid_pend);
    // In TURN after a CPU access the request still high is the one just acked.
    go_cpu    = free && !go_vid && cpu_req && !((state == TURN) && last_cpu);
    rd_nxt    = go_cpu ? cpu_rnw : cpu_rd;
    unique case (state)
      IDLE, TURN: begin
        if (go_vid)      state_nxt = VID_ADDR;
        else if (go_cpu) state_nxt = CPU_ADDR;
        else             state_nxt = IDLE;
      end
      VID_ADDR: state_nxt = VID_DATA;
      VID_DATA: state_nxt = TURN;
      CPU_ADDR: state_nxt = CPU_ACC;
      CPU_ACC:  if (acc_cnt == 2'd0) state_nxt = TURN;
      default:  state_nxt = IDLE;
    endcase
  end

  // State, counters, capture registers and enables decoded from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the enables reset high asynchronously so every buffer and RAM
      // strobe is released at once, even in the middle of an access.
      state     <= IDLE;
      acc_cnt   <= 2'd0;
      vid_pend  <= 1'b0;
      vid_ovr   <= 1'b0;
      cpu_rd    <= 1'b1;
      last_cpu  <= 1'b0;
      cpu_ack   <= 1'b0;
      vid_valid <= 1'b0;
      cpu_din   <= '0;
      vid_data  <= '0;
      cpu_a_gn  <= 1'b1;
      cpu_d_gn  <= 1'b1;
      vid_a_gn  <= 1'b1;
      ram_oen   <= 1'b1;
      ram_wen   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values computed by the combinational block.
      state     <= state_nxt;
      cpu_ack   <= 1'b0;
      vid_valid <= 1'b0;

      if (go_cpu) cpu_rd <= cpu_rnw;

      if (state == CPU_ADDR)                         acc_cnt <= ACC_LOAD;
      else if (state == CPU_ACC && acc_cnt != 2'd0) acc_cnt <= acc_cnt - 2'd1;

      if (state == VID_DATA) begin
        vid_data  <= ram_dq_in;
        vid_valid <= 1'b1;
        last_cpu  <= 1'b0;
      end

      if (state == CPU_ACC && acc_cnt == 2'd0) begin
        cpu_ack  <= 1'b1;
        last_cpu <= 1'b1;
        if (cpu_rd) cpu_din <= ram_dq_in;
      end

      // A request arriving while the bus is busy waits in vid_pend; a second
      // one before it is serviced is dropped and flagged.
      if (go_vid)                vid_pend <= 1'b0;
      else if (vid_req && !free) vid_pend <= 1'b1;
      if (vid_req && vid_pend)   vid_ovr  <= 1'b1;

      cpu_a_gn <= !(state_nxt == CPU_ADDR || state_nxt == CPU_ACC);
      cpu_d_gn <= !((state_nxt == CPU_ADDR || state_nxt == CPU_ACC) && !rd_nxt);
      vid_a_gn <= !(state_nxt == VID_ADDR || state_nxt == VID_DATA);
      ram_oen  <= !(state_nxt == VID_ADDR || state_nxt == VID_DATA ||
                    (state_nxt == CPU_ACC && rd_nxt));
      ram_wen  <= !(state_nxt == CPU_ACC && !rd_nxt);
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter: a transaction-level schedule model
// predicts bus ownership windows and captured data; expected completions go
// into a scoreboard queue that a separate monitor drains as the DUT reports.
module tb_ram_bus_arbiter;

  localparam int ACC = 2;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cpu_req, cpu_rnw, vid_req;
  logic [DW-1:0] ram_dq_in;
  logic [DW-1:0] cpu_din, vid_data;
  logic          cpu_ack, cpu_waitn, vid_valid, vid_ovr;
  logic          cpu_a_gn, cpu_d_gn, vid_a_gn, ram_oen, ram_wen;

  ram_bus_arbiter #(.ACC_CYC(ACC), .DW(DW)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_waitn(cpu_waitn),
    .vid_req(vid_req), .vid_data(vid_data), .vid_valid(vid_valid),
    .vid_ovr(vid_ovr), .ram_dq_in(ram_dq_in),
    .cpu_a_gn(cpu_a_gn), .cpu_d_gn(cpu_d_gn), .vid_a_gn(vid_a_gn),
    .ram_oen(ram_oen), .ram_wen(ram_wen)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------------------------------------------------------------
  // Reference model: bus ownership as segments on an edge timeline.
  // A video segment starting at edge S owns the bus for edges S..S+1 and
  // captures at S+2; a CPU segment drives address at S, strobes S+1..S+ACC,
  // acks at S+1+ACC. The next grant decision is at the edge after capture.
  // ---------------------------------------------------------------------
  typedef enum {SEG_NONE, SEG_VID, SEG_CPU} seg_e;
  typedef struct {
    bit            is_vid;
    bit            chk;
    logic [DW-1:0] data;
  } sb_t;

  sb_t           sb_q[$];
  int unsigned   edge_n = 0;
  int unsigned   next_dec = 0;
  int unsigned   seg_start = 0;
  seg_e          seg = SEG_NONE;
  bit            seg_wr, m_pend, m_ovr, m_inelig;
  logic [DW-1:0] m_vid_data, m_cpu_din;
  logic [4:0]    exp_en;   // {cpu_a_gn, cpu_d_gn, vid_a_gn, ram_oen, ram_wen}
  bit            exp_ack, exp_valid;

  int cnt_valid = 0, cnt_ack = 0, cnt_wen_low = 0, cnt_dgn_low = 0, cnt_vida_low = 0;

  task automatic model_step();
    edge_n = edge_n + 1;
    if (!rstn) begin
      seg = SEG_NONE; next_dec = 0; m_pend = 0; m_ovr = 0;
      m_vid_data = '0; m_cpu_din = '0;
      exp_en = 5'h1F; exp_ack = 0; exp_valid = 0;
      sb_q.delete();
    end else begin
      exp_ack = 0;
      exp_valid = 0;
      if (seg == SEG_VID && edge_n == seg_start + 2) begin
        m_vid_data = ram_dq_in;
        exp_valid  = 1;
        sb_q.push_back('{is_vid: 1'b1, chk: 1'b1, data: ram_dq_in});
      end
      if (seg == SEG_CPU && edge_n == seg_start + 1 + ACC) begin
        exp_ack = 1;
        if (!seg_wr) m_cpu_din = ram_dq_in;
        sb_q.push_back('{is_vid: 1'b0, chk: !seg_wr, data: ram_dq_in});
      end
      if (edge_n >= next_dec) begin
        m_inelig = (seg == SEG_CPU);
        if (vid_req || m_pend) begin
          if (vid_req && m_pend) m_ovr = 1;
          m_pend = 0;
          seg = SEG_VID; seg_start = edge_n; next_dec = edge_n + 3;
        end else if (cpu_req && !m_inelig) begin
          seg = SEG_CPU; seg_start = edge_n; seg_wr = !cpu_rnw;
          next_dec = edge_n + 2 + ACC;
        end else begin
          seg = SEG_NONE; next_dec = edge_n + 1;
        end
      end else if (vid_req) begin
        if (m_pend) m_ovr = 1;
        else        m_pend = 1;
      end
      exp_en = 5'h1F;
      if (seg == SEG_VID && edge_n < seg_start + 2) exp_en = 5'b11001;
      if (seg == SEG_CPU && edge_n == seg_start) exp_en = {1'b0, !seg_wr, 3'b111};
      if (seg == SEG_CPU && edge_n > seg_start && edge_n <= seg_start + ACC)
        exp_en = {1'b0, !seg_wr, 1'b1, seg_wr, !seg_wr};
    end
  endtask

  // Monitor: compares outputs every cycle and drains the scoreboard.
  task automatic monitor_step();
    logic [4:0] en = {cpu_a_gn, cpu_d_gn, vid_a_gn, ram_oen, ram_wen};
    bit ack_e = rstn && exp_ack;
    sb_t e;
    if (!rstn) begin
      check("rst_enables", en, 5'h1F);
      check("rst_cpu_ack", cpu_ack, 1'b0);
      check("rst_vid_valid", vid_valid, 1'b0);
      check("rst_vid_ovr", vid_ovr, 1'b0);
      check("rst_cpu_din", cpu_din, '0);
      check("rst_vid_data", vid_data, '0);
    end else begin
      check("enables", en, exp_en);
      check("cpu_ack", cpu_ack, exp_ack);
      check("vid_valid", vid_valid, exp_valid);
      check("vid_ovr", vid_ovr, m_ovr);
      check("vid_data_hold", vid_data, m_vid_data);
      check("cpu_din_hold", cpu_din, m_cpu_din);
      for (int i = 0; i < 2; i++) begin
        if ((i == 0) ? vid_valid : cpu_ack) begin
          if (sb_q.size() == 0) fail_now("sb_unexpected_output");
          else begin
            e = sb_q.pop_front();
            check("sb_kind", i == 0, e.is_vid);
            if (e.chk) check("sb_data", (i == 0) ? vid_data : cpu_din, e.data);
          end
        end
      end
      if (sb_q.size() != 0) begin
        fail_now("sb_missing_output");
        sb_q.delete();
      end
    end
    check("addr_excl", !(cpu_a_gn == 1'b0 && vid_a_gn == 1'b0), 1'b1);
    check("cpu_waitn", cpu_waitn, !(cpu_req && !ack_e));
    if (vid_valid)  cnt_valid++;
    if (cpu_ack)    cnt_ack++;
    if (!ram_wen)   cnt_wen_low++;
    if (!cpu_d_gn)  cnt_dgn_low++;
    if (!vid_a_gn)  cnt_vida_low++;
  endtask

  initial forever begin @(posedge clk); model_step();   end
  initial forever begin @(negedge clk); monitor_step(); end

  // ---------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the falling edge.
  // ---------------------------------------------------------------------
  task automatic drive(input logic cr, input logic rnw, input logic vr, input logic [DW-1:0] dq);
    @(negedge clk); #1;
    cpu_req = cr; cpu_rnw = rnw; vid_req = vr; ram_dq_in = dq;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, cpu_rnw, 1'b0, DW'($urandom));
  endtask

  // One CPU access held until ack; vmask[k] is the vid_req level for edge Ek.
  // a_k / ack_k are the cycle indices (after edge Ek) of first address enable
  // and of the ack.
  task automatic cpu_run(input logic rnw, input logic [15:0] vmask,
                         output int a_k, output int ack_k);
    logic got;
    a_k = -1;
    ack_k = -1;
    drive(1'b1, rnw, vmask[0], DW'($urandom));
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      got = cpu_ack;
      if (a_k < 0 && !cpu_a_gn) a_k = k;
      if (k == 0) check("waitn_low_while_req", cpu_waitn, 1'b0);
      if (got) begin
        ack_k = k;
        check("waitn_high_with_ack", cpu_waitn, 1'b1);
      end
      #1;
      vid_req   = (k + 1 < 16) ? vmask[k+1] : 1'b0;
      ram_dq_in = DW'($urandom);
      if (got) begin
        cpu_req = 1'b0;
        break;
      end
    end
    if (ack_k < 0) begin
      fail_now("cpu_ack_timeout");
      cpu_req = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  int c_v, c_a, c_w, c_d, c_l, a_k, ack_k, wait_cnt;
  logic got;

  initial begin
    cpu_req = 1'b0; cpu_rnw = 1'b1; vid_req = 1'b0; ram_dq_in = '0;
    rstn = 1'b0;
    #12;
    check("reset_cpu_a_gn", cpu_a_gn, 1'b1);
    check("reset_cpu_d_gn", cpu_d_gn, 1'b1);
    check("reset_vid_a_gn", vid_a_gn, 1'b1);
    check("reset_ram_oen", ram_oen, 1'b1);
    check("reset_ram_wen", ram_wen, 1'b1);
    check("reset_cpu_ack", cpu_ack, 1'b0);
    check("reset_vid_valid", vid_valid, 1'b0);
    check("reset_vid_ovr", vid_ovr, 1'b0);
    check("reset_cpu_waitn", cpu_waitn, 1'b1);
    @(negedge clk); #1; rstn = 1'b1;
    idle(2);

    // Single video read with 0xA5 on the bus.
    c_v = cnt_valid; c_l = cnt_vida_low;
    drive(1'b0, 1'b1, 1'b1, 8'hA5);
    repeat (5) drive(1'b0, 1'b1, 1'b0, 8'hA5);
    check("vid_rd_pulses", cnt_valid - c_v, 1);
    check("vid_rd_addr_cycles", cnt_vida_low - c_l, 2);
    check("vid_rd_data", vid_data, 8'hA5);

    // CPU write, request held through the ack cycle.
    c_a = cnt_ack; c_w = cnt_wen_low; c_d = cnt_dgn_low;
    cpu_run(1'b0, 16'h0000, a_k, ack_k);
    idle(6);
    check("wr_addr_first_cycle", a_k, 0);
    check("wr_ack_cycle", ack_k, ACC + 1);
    check("wr_wen_cycles", cnt_wen_low - c_w, ACC);
    check("wr_dgn_cycles", cnt_dgn_low - c_d, ACC + 1);
    check("wr_single_ack", cnt_ack - c_a, 1);

    // CPU read and video request on the same edge: video first.
    c_a = cnt_ack; c_v = cnt_valid;
    cpu_run(1'b1, 16'h0001, a_k, ack_k);
    idle(6);
    check("sim_cpu_addr_cycle", a_k, 3);
    check("sim_cpu_ack_cycle", ack_k, 4 + ACC);
    check("sim_vid_pulses", cnt_valid - c_v, 1);
    check("sim_cpu_acks", cnt_ack - c_a, 1);

    // Back-to-back video at one request per 3 clocks.
    c_v = cnt_valid;
    repeat (5) begin
      drive(1'b0, 1'b1, 1'b1, DW'($urandom));
      idle(2);
    end
    idle(4);
    check("b2b_vid_pulses", cnt_valid - c_v, 5);
    check("b2b_no_overrun", vid_ovr, 1'b0);

    // Two video requests during one CPU access: overrun, one video access.
    c_a = cnt_ack; c_v = cnt_valid;
    cpu_run(1'b0, 16'h0006, a_k, ack_k);
    idle(8);
    check("ovr_set", vid_ovr, 1'b1);
    check("ovr_one_vid_access", cnt_valid - c_v, 1);
    check("ovr_cpu_acks", cnt_ack - c_a, 1);
    idle(5);
    check("ovr_sticky", vid_ovr, 1'b1);

    // Reset in the middle of a write strobe.
    c_a = cnt_ack;
    drive(1'b1, 1'b0, 1'b0, DW'($urandom));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!ram_wen) break;
    end
    check("midrst_in_write", ram_wen, 1'b0);
    #1; rstn = 1'b0; cpu_req = 1'b0;
    #1;
    check("midrst_wen_released", ram_wen, 1'b1);
    check("midrst_dgn_released", cpu_d_gn, 1'b1);
    check("midrst_cpu_a_released", cpu_a_gn, 1'b1);
    check("midrst_no_ack", cpu_ack, 1'b0);
    idle(2);
    @(negedge clk); #1; rstn = 1'b1;
    idle(6);
    check("midrst_no_ack_after", cnt_ack - c_a, 0);
    check("midrst_idle_enables", {cpu_a_gn, cpu_d_gn, vid_a_gn, ram_oen, ram_wen}, 5'h1F);

    // Randomized traffic under the CPU handshake.
    wait_cnt = 0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      got = cpu_ack;
      #1;
      ram_dq_in = DW'($urandom);
      vid_req   = ($urandom_range(0, 4) == 0);
      if (cpu_req) begin
        wait_cnt++;
        if (got) cpu_req = 1'b0;
        else if (wait_cnt > 100) begin
          fail_now("rand_cpu_ack_timeout");
          cpu_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        cpu_req  = 1'b1;
        cpu_rnw  = 1'($urandom_range(0, 1));
        wait_cnt = 0;
      end
    end
    for (int k = 0; k < 40 && cpu_req; k++) begin
      @(negedge clk);
      got = cpu_ack;
      #1;
      vid_req = 1'b0;
      if (got) cpu_req = 1'b0;
    end
    if (cpu_req) begin
      fail_now("drain_cpu_ack_timeout");
      cpu_req = 1'b0;
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_bus_arbiter.md
# ram_bus_arbiter

Time-multiplexes a shared board RAM bus between the CPU port and the video scan port. It generates the active-low enables for the 74244 buffers that gate each requester onto the bus, plus the RAM strobes. It sits directly upstream of those buffers and captures read data returned on the bus. It guarantees one dead cycle, with all enables released, between bus-owner changes, so buffer outputs never contend.

## Interface
- `ACC_CYC`, default 2: CPU access strobe length in clocks; legal range 1..4.
- `DW`, default 8: data width.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  level request; held until `cpu_ack`.
- `cpu_rnw`  in  1  1 = read, 0 = write; stable while `cpu_req` is high.
- `cpu_din`  out  DW  captured CPU read data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_waitn`  out  1  combinational: `~(cpu_req & ~cpu_ack)`.
- `vid_req`  in  1  one-cycle read request pulse.
- `vid_data`  out  DW  captured video read data.
- `vid_valid`  out  1  one-cycle pulse; `vid_data` is valid in that cycle.
- `vid_ovr`  out  1  sticky overrun flag.
- `ram_dq_in`  in  DW  RAM bus read data.
- `cpu_a_gn`  out  1  CPU address buffer enable, active-low.
- `cpu_d_gn`  out  1  CPU write-data buffer enable, active-low.
- `vid_a_gn`  out  1  video address buffer enable, active-low.
- `ram_oen`  out  1  RAM output enable, active-low.
- `ram_wen`  out  1  RAM write enable, active-low.

## Operation
- States: IDLE, VID_ADDR, VID_DATA, CPU_ADDR, CPU_ACC, TURN.
- All enable and strobe outputs are registered and decoded from state.
  - VID_ADDR and VID_DATA: `vid_a_gn=0`, `ram_oen=0`.
  - CPU_ADDR: `cpu_a_gn=0`; if write, also `cpu_d_gn=0`.
  - CPU_ACC: `cpu_a_gn=0`. Read: `ram_oen=0`. Write: `cpu_d_gn=0`, `ram_wen=0`.
  - IDLE and TURN: all enables and strobes high.
- `cpu_a_gn` and `vid_a_gn` are never both low.
- `vid_pend`:
  - Set by `vid_req` in any state other than IDLE or TURN.
  - Cleared on entry to VID_ADDR.
  - A `vid_req` while `vid_pend` is already set sets `vid_ovr`. The extra request is dropped.
- Decision rule from IDLE or TURN: if `vid_req` or `vid_pend` → VID_ADDR; else if `cpu_req` (and eligible) → CPU_ADDR; else → IDLE. Video always wins.
- Eligibility: in TURN following a CPU access, `cpu_req` is ignored, because it is the just-acked request. TURN following a video access honours `cpu_req`.
- Transitions:
  - VID_ADDR → VID_DATA (1 clock).
  - VID_DATA → TURN. On this edge: `vid_data <= ram_dq_in`, `vid_valid <= 1`.
  - CPU_ADDR → CPU_ACC.
  - CPU_ACC lasts exactly `ACC_CYC` clocks (2-bit down-counter), then → TURN. On this edge: `cpu_ack <= 1`; on reads also `cpu_din <= ram_dq_in`.
- An access in progress is never pre-empted.
- Reset (async, any time, including mid-access):
  - State IDLE; all enables and strobes 1.
  - `cpu_ack=0`, `vid_valid=0`, `vid_ovr=0`, `vid_pend=0`, `cpu_din=0`, `vid_data=0`.
  - An interrupted write is abandoned without ack. The CPU must re-request.

## Timing
- Video: `vid_req` sampled at edge E0.
  - `vid_a_gn` low in cycles E0..E2.
  - `vid_valid` high in cycle E2..E3 and carries `ram_dq_in` as sampled at E2.
  - TURN in cycle E2..E3.
- CPU, from IDLE, `cpu_req` sampled at E0:
  - `cpu_a_gn` low from E0 to E1+`ACC_CYC`.
  - `ram_wen`/`ram_oen` low from E1 to E1+`ACC_CYC`.
  - `cpu_ack` high for the cycle after E1+`ACC_CYC`.
  - `cpu_waitn` low from `cpu_req` rise until `cpu_ack`.
- Minimum owner-change gap: one full clock with every enable high (TURN).
- Back-to-back video requests are serviced at one per 3 clocks without overrun.

## Test plan
- Reset with `cpu_req=0`:
  - All `*_gn`, `ram_oen`, `ram_wen` = 1.
  - `cpu_ack=0`, `vid_valid=0`, `vid_ovr=0`, `cpu_waitn=1`.
- Video read: `vid_req` pulse with `ram_dq_in=0xA5` → `vid_a_gn` and `ram_oen` low for exactly 2 clocks; `vid_valid` pulses with `vid_data=0xA5` 2 edges after the request edge.
- CPU write, `ACC_CYC=2`:
  - `cpu_d_gn` low 3 clocks; `ram_wen` low exactly 2 clocks.
  - `cpu_ack` 1 clock; `cpu_waitn` returns to 1 with the ack.
  - `cpu_req` held one extra cycle does not start a second access.
- Simultaneous `cpu_req` and `vid_req` at E0:
  - Video runs E0–E2; TURN at E2; `cpu_a_gn` falls at E3.
  - `cpu_ack` follows E6 (with `ACC_CYC=2`).
  - No cycle has both address enables low.
- Two `vid_req` pulses during one CPU access → `vid_ovr` = 1 and stays 1; exactly one video access follows TURN.
- `rstn` asserted during CPU_ACC of a write → `ram_wen` and `cpu_d_gn` go high with no clock edge; no `cpu_ack`; state IDLE after release.
